// File: rtl/scan_pkg.sv
// Shared types and constants for the raster-scan sequencer.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } scan_state_t;

  localparam int WIN_SIZE = 3;
  localparam int MIN_DIM  = 3;

endpackage

// File: rtl/scan_pos_gen.sv
// Column/row/address position generator for the raster scan.
// Clear and load take priority over advance; last_pixel is combinational.
module scan_pos_gen #(
  parameter int COL_BITS  = 10,
  parameter int ROW_BITS  = 10,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 advance,
  input  logic [COL_BITS-1:0]  width,
  input  logic [ROW_BITS-1:0]  height,
  input  logic [ADDR_BITS-1:0] base_addr,
  output logic [COL_BITS-1:0]  col,
  output logic [ROW_BITS-1:0]  row,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 last_pixel
);

  logic col_at_end;

  assign col_at_end = (col == width - COL_BITS'(1));
  assign last_pixel = col_at_end && (row == height - ROW_BITS'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else begin
      if (clear) begin
        col <= '0;
        row <= '0;
      end else if (advance) begin
        if (col_at_end) begin
          col <= '0;
          row <= row + ROW_BITS'(1);
        end else begin
          col <= col + COL_BITS'(1);
        end
      end

      // Address wraps naturally modulo 2^ADDR_BITS.
      if (load)
        addr <= base_addr;
      else if (advance)
        addr <= addr + ADDR_BITS'(1);
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Raster-scan controller: per-pixel read handshake, 3x3 window strobe with backpressure.
// Optional SCAN_ABORT_EN adds an abort input that returns the sequencer to IDLE.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int COL_BITS  = 10,
  parameter int ROW_BITS  = 10,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [COL_BITS-1:0]  img_width,
  input  logic [ROW_BITS-1:0]  img_height,
  input  logic [ADDR_BITS-1:0] base_addr,
`ifdef SCAN_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 rd_req,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 rd_ack,
  output logic                 win_valid,
  output logic [COL_BITS-1:0]  win_col,
  output logic [ROW_BITS-1:0]  win_row,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 cfg_err
);

  scan_state_t state, next_state;

  logic [COL_BITS-1:0] width_q;
  logic [ROW_BITS-1:0] height_q;
  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic                last_pixel;

  logic pos_clear, pos_load, pos_advance;
  logic cfg_latch, cfg_reject;
  logic abort_hit, dims_ok, in_window;

  logic rd_req_d, win_valid_d, busy_d, frame_done_d, cfg_err_d, win_load;

`ifdef SCAN_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign dims_ok   = (img_width  >= COL_BITS'(MIN_DIM)) &&
                     (img_height >= ROW_BITS'(MIN_DIM));
  assign in_window = (col >= COL_BITS'(WIN_SIZE - 1)) &&
                     (row >= ROW_BITS'(WIN_SIZE - 1));

  scan_pos_gen #(
    .COL_BITS (COL_BITS),
    .ROW_BITS (ROW_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_pos_gen (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (pos_clear),
    .load      (pos_load),
    .advance   (pos_advance),
    .width     (width_q),
    .height    (height_q),
    .base_addr (base_addr),
    .col       (col),
    .row       (row),
    .addr      (rd_addr),
    .last_pixel(last_pixel)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      width_q  <= '0;
      height_q <= '0;
    end else begin
      state <= next_state;
      if (cfg_latch) begin
        width_q  <= img_width;
        height_q <= img_height;
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state  = state;
    pos_clear   = 1'b0;
    pos_load    = 1'b0;
    pos_advance = 1'b0;
    cfg_latch   = 1'b0;
    cfg_reject  = 1'b0;
    if (abort_hit) begin
      next_state = IDLE;
      pos_clear  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (dims_ok) begin
              next_state = REQ;
              cfg_latch  = 1'b1;
              pos_clear  = 1'b1;
              pos_load   = 1'b1;
            end else begin
              cfg_reject = 1'b1;
            end
          end
        end
        REQ: begin
          if (rd_ack) begin
            if (in_window) begin
              next_state = EMIT;
            end else begin
              pos_advance = 1'b1;
              next_state  = last_pixel ? DONE : REQ;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            pos_advance = 1'b1;
            next_state  = last_pixel ? DONE : REQ;
          end
        end
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are decoded from next_state and registered, so they align with the state they describe.
  always_comb begin
    rd_req_d     = (next_state == REQ);
    win_valid_d  = (next_state == EMIT);
    busy_d       = (next_state != IDLE);
    frame_done_d = (next_state == DONE);
    cfg_err_d    = cfg_reject;
    win_load     = (state == REQ) && (next_state == EMIT);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_req     <= 1'b0;
      win_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
    end else begin
      rd_req     <= rd_req_d;
      win_valid  <= win_valid_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      cfg_err    <= cfg_err_d;
      if (win_load) begin
        win_col <= col - COL_BITS'(1);
        win_row <= row - ROW_BITS'(1);
      end
    end
  end

endmodule
